// File: rtl/snax_tcdm_responder_if.sv
// TCDM request (q) / response (p) channel bundle between SNAX accelerator ports
// and the banked responder. All per-port fields are packed, port p at slice p.
interface snax_tcdm_responder_if #(
  parameter int NumPorts  = 16,
  parameter int DataWidth = 64,
  parameter int AddrWidth = 17
);
  logic [NumPorts-1:0]             q_valid_i;
  logic [NumPorts-1:0]             q_ready_o;
  logic [NumPorts*AddrWidth-1:0]   q_addr_i;
  logic [NumPorts-1:0]             q_write_i;
  logic [NumPorts*DataWidth-1:0]   q_data_i;
  logic [NumPorts*DataWidth/8-1:0] q_strb_i;
  logic [NumPorts-1:0]             p_valid_o;
  logic [NumPorts*DataWidth-1:0]   p_data_o;

  modport master (
    output q_valid_i, q_addr_i, q_write_i, q_data_i, q_strb_i,
    input  q_ready_o, p_valid_o, p_data_o
  );

  modport slave (
    input  q_valid_i, q_addr_i, q_write_i, q_data_i, q_strb_i,
    output q_ready_o, p_valid_o, p_data_o
  );
endinterface

// File: rtl/snax_tcdm_responder.sv
// Banked multi-port TCDM responder: per-bank round-robin arbitration, strobed
// writes, fixed one-cycle response latency, saturating conflict counter.
module snax_tcdm_responder #(
  parameter int NumPorts  = 16,
  parameter int NumBanks  = 32,
  parameter int DataWidth = 64,
  parameter int AddrWidth = 17,
  parameter int BankDepth = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  snax_tcdm_responder_if.slave tcdm,
  output logic [31:0]          conflict_cnt_o
);
  localparam int NumBytes = DataWidth / 8;
  localparam int OffW     = (NumBytes > 1) ? $clog2(NumBytes) : 0;
  localparam int BankW    = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int RowW     = (BankDepth > 1) ? $clog2(BankDepth) : 1;
  localparam int PortW    = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [DataWidth-1:0] mem [NumBanks][BankDepth];
  logic [PortW-1:0]     rr_ptr [NumBanks];

  logic [AddrWidth-1:0] port_word [NumPorts];
  logic [AddrWidth-1:0] port_row  [NumPorts];
  logic [BankW-1:0]     port_bank [NumPorts];
  logic [NumPorts-1:0]  port_in_range;

  logic [NumBanks-1:0]  gnt_any;
  logic [PortW-1:0]     gnt_idx [NumBanks];
  logic [NumPorts-1:0]  ready;
  logic [NumPorts-1:0]  xfer;
  logic [31:0]          pop;
  logic [32:0]          cnt_sum;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      port_word[p]     = tcdm.q_addr_i[p*AddrWidth +: AddrWidth] >> OffW;
      port_bank[p]     = port_word[p][BankW-1:0];
      port_row[p]      = port_word[p] >> BankW;
      port_in_range[p] = (port_row[p] < AddrWidth'(BankDepth));
    end
  end

  // Handshake: a request transfers on q_valid_i[p] & q_ready_o[p]. Ready depends
  // only on the current valids/addresses and the pointers, never on the p side.
  always_comb begin
    logic [PortW:0] s;
    logic [PortW-1:0] idx;
    ready   = '0;
    gnt_any = '0;
    s       = '0;
    idx     = '0;
    for (int b = 0; b < NumBanks; b++) gnt_idx[b] = '0;
    if (!rst_i) begin
      for (int b = 0; b < NumBanks; b++) begin
        for (int k = 0; k < NumPorts; k++) begin
          s = {1'b0, rr_ptr[b]} + (PortW+1)'(k);
          if (s >= (PortW+1)'(NumPorts)) s = s - (PortW+1)'(NumPorts);
          idx = s[PortW-1:0];
          if (!gnt_any[b] && tcdm.q_valid_i[idx] && (port_bank[idx] == BankW'(b))) begin
            gnt_any[b] = 1'b1;
            gnt_idx[b] = idx;
            ready[idx] = 1'b1;
          end
        end
      end
    end
  end

  assign tcdm.q_ready_o = ready;
  assign xfer           = tcdm.q_valid_i & ready;

  always_comb begin
    pop = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (tcdm.q_valid_i[p] && !ready[p]) pop = pop + 32'd1;
    end
    cnt_sum = {1'b0, conflict_cnt_o} + {1'b0, pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conflict_cnt_o <= '0;
      for (int b = 0; b < NumBanks; b++) rr_ptr[b] <= '0;
    end else begin
      conflict_cnt_o <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
      for (int b = 0; b < NumBanks; b++) begin
        if (gnt_any[b]) begin
          rr_ptr[b] <= (gnt_idx[b] == PortW'(NumPorts - 1)) ? '0 : gnt_idx[b] + PortW'(1);
        end
      end
    end
  end

  // Writes land at the edge; out-of-range rows are silently dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NumBanks; b++)
        for (int r = 0; r < BankDepth; r++) mem[b][r] <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (gnt_any[b] && tcdm.q_write_i[gnt_idx[b]] && port_in_range[gnt_idx[b]]) begin
          for (int i = 0; i < NumBytes; i++) begin
            if (tcdm.q_strb_i[gnt_idx[b]*NumBytes + i])
              mem[b][port_row[gnt_idx[b]][RowW-1:0]][i*8 +: 8] <=
                tcdm.q_data_i[gnt_idx[b]*DataWidth + i*8 +: 8];
          end
        end
      end
    end
  end

  // Reads sample the pre-edge contents; write acks and idle cycles return zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tcdm.p_valid_o <= '0;
      tcdm.p_data_o  <= '0;
    end else begin
      tcdm.p_valid_o <= xfer;
      for (int p = 0; p < NumPorts; p++) begin
        if (xfer[p] && !tcdm.q_write_i[p] && port_in_range[p])
          tcdm.p_data_o[p*DataWidth +: DataWidth] <= mem[port_bank[p]][port_row[p][RowW-1:0]];
        else
          tcdm.p_data_o[p*DataWidth +: DataWidth] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_snax_tcdm_responder.sv
// Directed bench for snax_tcdm_responder: write/read, bank conflicts, strobes,
// read-after-write, out-of-range and mid-operation reset.
module tb_snax_tcdm_responder;
  localparam int NP = 16;
  localparam int DW = 64;
  localparam int AW = 17;

  logic        clk;
  logic        rst;
  logic [31:0] conflict_cnt;
  int          total;
  int          bad;
  logic [DW-1:0] exp_q[$];

  snax_tcdm_responder_if #(.NumPorts(NP), .DataWidth(DW), .AddrWidth(AW)) tcdm ();

  snax_tcdm_responder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tcdm           (tcdm.slave),
    .conflict_cnt_o (conflict_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    tcdm.q_valid_i = '0;
    tcdm.q_addr_i  = '0;
    tcdm.q_write_i = '0;
    tcdm.q_data_i  = '0;
    tcdm.q_strb_i  = '0;
  endtask

  task automatic req(input int p, input logic [AW-1:0] addr, input logic wr,
                     input logic [DW-1:0] data, input logic [7:0] strb);
    tcdm.q_valid_i[p]          = 1'b1;
    tcdm.q_addr_i[p*AW +: AW]  = addr;
    tcdm.q_write_i[p]          = wr;
    tcdm.q_data_i[p*DW +: DW]  = data;
    tcdm.q_strb_i[p*8 +: 8]    = strb;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [DW-1:0] pdata(input int p);
    return tcdm.p_data_o[p*DW +: DW];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle_all();
    #2;

    // Reset then idle; requests during reset must not be granted
    rst = 1'b1;
    tcdm.q_valid_i = '1;
    #1;
    check("ready_in_reset", DW'(tcdm.q_ready_o), 64'h0);
    step();
    idle_all();
    rst = 1'b0;
    step();
    check("rst_p_valid", DW'(tcdm.p_valid_o), 64'h0);
    check("rst_p_data0", pdata(0), 64'h0);
    check("rst_cnt", DW'(conflict_cnt), 64'h0);

    // All ports write distinct banks in one cycle
    for (int p = 0; p < NP; p++) req(p, AW'(p*8), 1'b1, 64'hA5A5_0000_0000_0000 + DW'(p), 8'hFF);
    #1;
    check("wr_all_ready", DW'(tcdm.q_ready_o), 64'hFFFF);
    step();
    check("wr_ack_valid", DW'(tcdm.p_valid_o), 64'hFFFF);
    check("wr_ack_data7", pdata(7), 64'h0);
    check("wr_ack_data15", pdata(15), 64'h0);
    for (int p = 0; p < NP; p++) begin
      req(p, AW'(p*8), 1'b0, '0, 8'h00);
      exp_q.push_back(64'hA5A5_0000_0000_0000 + DW'(p));
    end
    #1;
    check("rd_all_ready", DW'(tcdm.q_ready_o), 64'hFFFF);
    step();
    idle_all();
    check("rd_all_valid", DW'(tcdm.p_valid_o), 64'hFFFF);
    for (int p = 0; p < NP; p++) check($sformatf("rd_data%0d", p), pdata(p), exp_q.pop_front());
    check("no_conflict_cnt", DW'(conflict_cnt), 64'h0);
    step();
    check("idle_p_valid", DW'(tcdm.p_valid_o), 64'h0);

    // Bank conflict: ports 0, 3, 7 on 0x100 from reset -> grants 0, 3, 7, 0
    do_reset();
    req(0, 17'h100, 1'b0, '0, 8'h00);
    req(3, 17'h100, 1'b0, '0, 8'h00);
    req(7, 17'h100, 1'b0, '0, 8'h00);
    #1;
    check("cf_ready0", DW'(tcdm.q_ready_o), 64'h0001);
    check("cf_cnt0", DW'(conflict_cnt), 64'd0);
    step();
    check("cf_pvalid0", DW'(tcdm.p_valid_o), 64'h0001);
    check("cf_cnt1", DW'(conflict_cnt), 64'd2);
    check("cf_ready1", DW'(tcdm.q_ready_o), 64'h0008);
    step();
    check("cf_pvalid1", DW'(tcdm.p_valid_o), 64'h0008);
    check("cf_cnt2", DW'(conflict_cnt), 64'd4);
    check("cf_ready2", DW'(tcdm.q_ready_o), 64'h0080);
    step();
    check("cf_cnt3", DW'(conflict_cnt), 64'd6);
    check("cf_ready3", DW'(tcdm.q_ready_o), 64'h0001);
    step();
    check("cf_cnt4", DW'(conflict_cnt), 64'd8);
    idle_all();
    step();
    check("cf_cnt_hold", DW'(conflict_cnt), 64'd8);

    // Partial strobe
    req(1, 17'h40, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    step();
    req(1, 17'h40, 1'b1, 64'h0, 8'h0F);
    step();
    req(1, 17'h40, 1'b0, '0, 8'h00);
    step();
    idle_all();
    check("strb_valid", DW'(tcdm.p_valid_o), 64'h0002);
    check("strb_data", pdata(1), 64'hFFFF_FFFF_0000_0000);

    // Back-to-back read-after-write from different ports
    req(2, 17'h80, 1'b1, 64'h1234, 8'hFF);
    step();
    idle_all();
    req(5, 17'h80, 1'b0, '0, 8'h00);
    step();
    idle_all();
    check("raw_valid", DW'(tcdm.p_valid_o), 64'h0020);
    check("raw_data", pdata(5), 64'h1234);

    // Out of range (row 256 of bank 0): write dropped, read returns zero, no aliasing
    req(0, 17'h10000, 1'b1, 64'hDEAD, 8'hFF);
    step();
    req(0, 17'h10000, 1'b0, '0, 8'h00);
    step();
    check("oor_valid", DW'(tcdm.p_valid_o), 64'h0001);
    check("oor_data", pdata(0), 64'h0);
    req(0, 17'h0, 1'b0, '0, 8'h00);
    step();
    idle_all();
    check("oor_alias", pdata(0), 64'h0);

    // Reset while a read response is pending
    req(4, 17'h200, 1'b1, 64'h55, 8'hFF);
    step();
    req(4, 17'h200, 1'b0, '0, 8'h00);
    step();
    idle_all();
    check("pre_rst_data", pdata(4), 64'h55);
    req(4, 17'h200, 1'b0, '0, 8'h00);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", DW'(tcdm.p_valid_o), 64'h0);
    check("mid_rst_ready", DW'(tcdm.q_ready_o), 64'h0);
    step();
    rst = 1'b0;
    #1;
    step();
    idle_all();
    check("post_rst_valid", DW'(tcdm.p_valid_o), 64'h0010);
    check("post_rst_data", pdata(4), 64'h0);
    check("post_rst_cnt", DW'(conflict_cnt), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
